// File: rtl/uart_tx_arbiter_if.sv
// Bundle of requester lanes, TX FIFO write port and arbiter status.
// "master" is the side that owns the byte sources and the FIFO full flag.
// "slave" is the arbiter itself.
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DBITS   = 8
);
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ*DBITS-1:0] req_data;
    logic [NUM_REQ-1:0]       req_last;
    logic [NUM_REQ-1:0]       req_ready;
    logic                     tx_full;
    logic                     write_uart;
    logic [DBITS-1:0]         write_data;
    logic [2:0]               grant_id;
    logic                     busy;
    logic                     truncated;

    modport master (
        output req_valid, req_data, req_last, tx_full,
        input  req_ready, write_uart, write_data, grant_id, busy, truncated
    );

    modport slave (
        input  req_valid, req_data, req_last, tx_full,
        output req_ready, write_uart, write_data, grant_id, busy, truncated
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin, message-granular arbiter feeding the UART TX FIFO write port.
// A granted requester keeps the link until its last byte or the byte cap,
// and writes are spaced at least two cycles apart so a one-cycle-stale
// full flag can never overflow the FIFO.
module uart_tx_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DBITS     = 8,
    parameter int MAX_BYTES = 64,
    parameter int CNT_BITS  = 7
) (
    input logic              CLK,
    input logic              RST,
    uart_tx_arbiter_if.slave bus
);

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

    state_t              state;
    logic [CNT_BITS-1:0] byte_cnt;
    logic [2:0]          last_grant;
    logic [2:0]          grant_id;
    logic                write_uart_q;
    logic [DBITS-1:0]    write_data_q;
    logic                truncated_q;

    // Lanes are padded out to eight so a 3-bit index always fits exactly.
    logic [7:0]       valid_pad;
    logic [7:0]       last_pad;
    logic [7:0]       ready_pad;
    logic [DBITS-1:0] lane_data [8];

    logic [2:0] pick;
    logic       pick_found;
    logic [2:0] scan_idx;
    logic       accept;
    logic       at_cap;
    logic [DBITS-1:0] grant_data;

    assign valid_pad = 8'(bus.req_valid);
    assign last_pad  = 8'(bus.req_last);

    // Split the flat data bus into per-requester lanes; unused lanes read zero.
    for (genvar i = 0; i < 8; i++) begin : g_lane
        if (i < NUM_REQ) begin : g_used
            assign lane_data[i] = bus.req_data[i*DBITS +: DBITS];
        end else begin : g_unused
            assign lane_data[i] = '0;
        end
    end

    // Round-robin pick: first valid requester after the most recent grant.
    always_comb begin
        pick       = '0;
        pick_found = 1'b0;
        scan_idx   = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            scan_idx = 3'((int'(last_grant) + i) % NUM_REQ);
            if (!pick_found && valid_pad[scan_idx]) begin
                pick       = scan_idx;
                pick_found = 1'b1;
            end
        end
    end

    // Only the granted lane may be ready, and never while a write is in flight.
    always_comb begin
        ready_pad = '0;
        if (state == XFER) begin
            ready_pad[grant_id] = valid_pad[grant_id] & ~bus.tx_full & ~write_uart_q;
        end
    end

    assign accept     = ready_pad[grant_id];
    assign at_cap     = (byte_cnt == CNT_BITS'(MAX_BYTES - 1));
    assign grant_data = lane_data[grant_id];

    // Grant/transfer state machine with registered FIFO write and status pulses.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state        <= IDLE;
            byte_cnt     <= '0;
            last_grant   <= 3'(NUM_REQ - 1);
            grant_id     <= '0;
            write_uart_q <= 1'b0;
            write_data_q <= '0;
            truncated_q  <= 1'b0;
        end else begin
            write_uart_q <= 1'b0;
            truncated_q  <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        grant_id <= pick;
                        byte_cnt <= '0;
                        state    <= XFER;
                    end
                end
                XFER: begin
                    if (accept) begin
                        write_uart_q <= 1'b1;
                        write_data_q <= grant_data;
                        byte_cnt     <= byte_cnt + 1'b1;
                        if (last_pad[grant_id]) begin
                            last_grant <= grant_id;
                            state      <= IDLE;
                        end else if (at_cap) begin
                            last_grant  <= grant_id;
                            truncated_q <= 1'b1;
                            state       <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready  = ready_pad[NUM_REQ-1:0];
    assign bus.write_uart = write_uart_q;
    assign bus.write_data = write_data_q;
    assign bus.grant_id   = grant_id;
    assign bus.busy       = (state == XFER);
    assign bus.truncated  = truncated_q;

endmodule
